// File: rtl/rx_buff_pkg.sv
// Shared constants, types and address arithmetic for the correlator capture
// buffers, imported by both the capture (write) units and the buffer reader.
package rx_buff_pkg;

  localparam int UNIT_LINES = 256;
  localparam int BUFF_DEPTH = 128;
  localparam int N_UNITS    = 4;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;

  localparam int IDX_W  = $clog2(BUFF_DEPTH);
  localparam int UNIT_W = $clog2(N_UNITS);

  typedef logic [IDX_W-1:0]         idx_t;
  typedef logic [UNIT_W-1:0]        unit_t;
  typedef logic [ADDR_W-1:0]        addr_t;
  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } state_t;

  // The in-buffer position is computed at IDX_W bits so it wraps inside the
  // buffer, which is what makes the circular window contiguous in time.
  function automatic addr_t buff_addr(input unit_t unit, input logic buf_sel,
                                      input idx_t offset, input idx_t idx);
    idx_t pos;
    addr_t base;
    pos  = offset + idx;
    base = addr_t'(unit) * addr_t'(UNIT_LINES);
    if (buf_sel) base = base + addr_t'(BUFF_DEPTH);
    return base + addr_t'(pos);
  endfunction

endpackage

// File: rtl/rx_correlator_buff_reader_if.sv
// Control, shared-RAM read port and sample stream of the buffer reader.
// master = the reader, slave = its environment (RAM, controller, sink).
interface rx_correlator_buff_reader_if;
  import rx_buff_pkg::*;

  logic    istart;
  unit_t   iunit_sel;
  logic    ibuff_flag;
  idx_t    istart_offset;

  logic    oram_r_enable;
  addr_t   oram_r_address;
  sample_t iram_data_out;

  sample_t osample;
  idx_t    osample_index;
  logic    osample_valid;
  logic    isample_ready;
  logic    olast;

  logic    obusy;
  logic    odone;
  sample_t opeak_value;
  idx_t    opeak_index;

  modport master (
    input  istart, iunit_sel, ibuff_flag, istart_offset,
    output oram_r_enable, oram_r_address,
    input  iram_data_out,
    output osample, osample_index, osample_valid, olast,
    input  isample_ready,
    output obusy, odone, opeak_value, opeak_index
  );

  modport slave (
    output istart, iunit_sel, ibuff_flag, istart_offset,
    input  oram_r_enable, oram_r_address,
    output iram_data_out,
    input  osample, osample_index, osample_valid, olast,
    output isample_ready,
    input  obusy, odone, opeak_value, opeak_index
  );

endinterface

// File: rtl/rx_buff_addr_gen.sv
// Combinational (unit, buffer, offset, index) -> shared RAM line mapping,
// shared with the capture units so both sides agree on the layout.
module rx_buff_addr_gen
  import rx_buff_pkg::*;
(
  input  unit_t unit,
  input  logic  buf_sel,
  input  idx_t  offset,
  input  idx_t  idx,
  output addr_t addr
);

  assign addr = buff_addr(unit, buf_sel, offset, idx);

endmodule

// File: rtl/rx_correlator_buff_reader.sv
// Reads one finished 128-sample capture window oldest-first from the shared
// RAM, streams it on valid/ready and reports the window's signed peak.
module rx_correlator_buff_reader
  import rx_buff_pkg::*;
(
  input  logic crx_clk,
  input  logic rrx_rst,
  rx_correlator_buff_reader_if.master bus
);

  localparam idx_t LAST_IDX = idx_t'(BUFF_DEPTH - 1);

  state_t state;
  unit_t  unit_q;
  logic   buf_q;
  idx_t   offset_q;
  idx_t   idx;

  unit_t  gen_unit;
  logic   gen_buf;
  idx_t   gen_offset;
  idx_t   gen_idx;
  addr_t  addr_next;

  // In IDLE the address for sample 0 comes straight from the start request so
  // the first read can issue on the same edge that accepts istart.
  // NOTE: every signal driven in always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    gen_unit   = unit_q;
    gen_buf    = buf_q;
    gen_offset = offset_q;
    gen_idx    = idx + idx_t'(1);
    if (state == ST_IDLE) begin
      gen_unit   = bus.iunit_sel;
      gen_buf    = ~bus.ibuff_flag;
      gen_offset = bus.istart_offset;
      gen_idx    = '0;
    end
  end

  rx_buff_addr_gen u_addr_gen (
    .unit    (gen_unit),
    .buf_sel (gen_buf),
    .offset  (gen_offset),
    .idx     (gen_idx),
    .addr    (addr_next)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge values regardless of statement order.
  always_ff @(posedge crx_clk or negedge rrx_rst) begin
    if (!rrx_rst) begin
      state              <= ST_IDLE;
      unit_q             <= '0;
      buf_q              <= 1'b0;
      offset_q           <= '0;
      idx                <= '0;
      bus.oram_r_enable  <= 1'b0;
      bus.oram_r_address <= '0;
      bus.osample        <= '0;
      bus.osample_index  <= '0;
      bus.osample_valid  <= 1'b0;
      bus.olast          <= 1'b0;
      bus.obusy          <= 1'b0;
      bus.odone          <= 1'b0;
      bus.opeak_value    <= '0;
      bus.opeak_index    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.istart) begin
            unit_q             <= bus.iunit_sel;
            buf_q              <= ~bus.ibuff_flag;
            offset_q           <= bus.istart_offset;
            idx                <= '0;
            bus.obusy          <= 1'b1;
            bus.oram_r_enable  <= 1'b1;
            bus.oram_r_address <= addr_next;
            state              <= ST_REQ;
          end
        end

        ST_REQ: begin
          bus.oram_r_enable <= 1'b0;
          state             <= ST_WAIT;
        end

        ST_WAIT: begin
          bus.osample       <= bus.iram_data_out;
          bus.osample_index <= idx;
          bus.osample_valid <= 1'b1;
          bus.olast         <= (idx == LAST_IDX);
          // Strict compare keeps the earliest sample on ties.
          if ((idx == '0) || (bus.iram_data_out > bus.opeak_value)) begin
            bus.opeak_value <= bus.iram_data_out;
            bus.opeak_index <= idx;
          end
          state <= ST_OUT;
        end

        ST_OUT: begin
          if (bus.isample_ready) begin
            bus.osample_valid <= 1'b0;
            bus.olast         <= 1'b0;
            if (idx == LAST_IDX) begin
              bus.odone <= 1'b1;
              state     <= ST_DONE;
            end else begin
              idx                <= idx + idx_t'(1);
              bus.oram_r_enable  <= 1'b1;
              bus.oram_r_address <= addr_next;
              state              <= ST_REQ;
            end
          end
        end

        ST_DONE: begin
          bus.odone <= 1'b0;
          bus.obusy <= 1'b0;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_correlator_buff_reader.sv
// Self-checking bench for rx_correlator_buff_reader: table of windows plus
// hand-written sequences for ignored starts and mid-read reset.
module tb_rx_correlator_buff_reader;
  import rx_buff_pkg::*;

  logic crx_clk = 1'b0;
  logic rrx_rst = 1'b0;
  always #5 crx_clk = ~crx_clk;

  rx_correlator_buff_reader_if bus();

  rx_correlator_buff_reader dut (
    .crx_clk (crx_clk),
    .rrx_rst (rrx_rst),
    .bus     (bus)
  );

  typedef struct {
    unit_t   unit;
    logic    flag;
    idx_t    offset;
    int      pattern;   // 0: value = line, 1: -5 with -1 at indices 40 and 90
    int      rdy_mode;  // 0: ready high, 1: random with long stall at index 5
    sample_t peak;
    idx_t    peak_idx;
  } vec_t;

  typedef struct {
    sample_t sample;
    idx_t    index;
    logic    last;
  } exp_t;

  sample_t mem [0:1023];
  exp_t    exp_q[$];
  addr_t   addr_q[$];

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  int stall_cnt = 0;
  bit stalled_once = 0;
  bit prev_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input string got, input string req);
    checks++;
    errors++;
    $display("FAIL %s: got %s, required %s", name, got, req);
  endtask

  function automatic addr_t exp_addr(input vec_t v, input int i);
    int a;
    a = int'(v.unit) * 256 + (v.flag ? 0 : 128) + ((int'(v.offset) + i) % 128);
    return addr_t'(a);
  endfunction

  // Synchronous-read RAM model: data valid the cycle after the enable.
  always @(posedge crx_clk)
    if (bus.oram_r_enable) bus.iram_data_out <= mem[bus.oram_r_address];

  // Downstream ready generator.
  initial begin
    bus.isample_ready = 1'b0;
    forever begin
      @(posedge crx_clk);
      #1;
      if (rdy_mode == 0) begin
        bus.isample_ready = 1'b1;
      end else if (rdy_mode == 2) begin
        bus.isample_ready = !(bus.osample_valid && bus.osample_index == idx_t'(64));
      end else if (stall_cnt > 0) begin
        bus.isample_ready = 1'b0;
        stall_cnt--;
      end else if (bus.osample_valid && bus.osample_index == idx_t'(5) && !stalled_once) begin
        stalled_once = 1;
        stall_cnt = 9;
        bus.isample_ready = 1'b0;
      end else begin
        bus.isample_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitors: RAM reads against expected address order, stream against
  // scoreboard head on every valid cycle (covers stability under stall).
  always @(negedge crx_clk) begin
    if (!rrx_rst) begin
      prev_stall = 0;
    end else begin
      if (bus.oram_r_enable) begin
        if (addr_q.size() == 0) fail("extra_read", "unexpected read", "no read");
        else check("read_addr", 32'(bus.oram_r_address), 32'(addr_q.pop_front()));
        if (bus.osample_valid) fail("read_while_valid", "read enable", "idle RAM");
      end
      if (prev_stall) check("valid_held", 32'(bus.osample_valid), 32'd1);
      if (bus.osample_valid) begin
        if (exp_q.size() == 0) begin
          fail("extra_sample", "valid sample", "no sample");
        end else begin
          check("sample", bus.osample, exp_q[0].sample);
          check("sample_index", 32'(bus.osample_index), 32'(exp_q[0].index));
          check("last", 32'(bus.olast), 32'(exp_q[0].last));
          if (bus.isample_ready) void'(exp_q.pop_front());
        end
      end
      prev_stall = bus.osample_valid && !bus.isample_ready;
      if (bus.odone) done_cnt++;
    end
  end

  task automatic arm(input vec_t v);
    exp_t e;
    for (int a = 0; a < 1024; a++) mem[a] = (v.pattern == 0) ? sample_t'(a) : -32'sd5;
    if (v.pattern == 1) begin
      mem[exp_addr(v, 40)] = -32'sd1;
      mem[exp_addr(v, 90)] = -32'sd1;
    end
    exp_q.delete();
    addr_q.delete();
    for (int i = 0; i < 128; i++) begin
      addr_q.push_back(exp_addr(v, i));
      e.sample = mem[exp_addr(v, i)];
      e.index  = idx_t'(i);
      e.last   = (i == 127);
      exp_q.push_back(e);
    end
    stalled_once = 0;
    stall_cnt = 0;
    rdy_mode = v.rdy_mode;
  endtask

  task automatic start(input vec_t v);
    @(negedge crx_clk);
    bus.istart        = 1'b1;
    bus.iunit_sel     = v.unit;
    bus.ibuff_flag    = v.flag;
    bus.istart_offset = v.offset;
    @(posedge crx_clk);
    #1;
    bus.istart = 1'b0;
    check("busy_set", 32'(bus.obusy), 32'd1);
  endtask

  task automatic run_window(input vec_t v);
    int cyc, first_v, d0;
    arm(v);
    d0 = done_cnt;
    start(v);
    cyc = 1;
    first_v = -1;
    while (!bus.odone && cyc < 5000) begin
      @(posedge crx_clk);
      #1;
      cyc++;
      if (bus.osample_valid && first_v < 0) first_v = cyc;
    end
    if (!bus.odone) fail("done_timeout", "no odone", "odone pulse");
    if (v.rdy_mode == 0) begin
      check("first_valid_cycle", 32'(first_v), 32'd3);
      check("done_cycle", 32'(cyc), 32'd385);
    end
    check("busy_in_done", 32'(bus.obusy), 32'd1);
    check("peak_value", bus.opeak_value, v.peak);
    check("peak_index", 32'(bus.opeak_index), 32'(v.peak_idx));
    @(posedge crx_clk);
    #1;
    check("busy_clear", 32'(bus.obusy), 32'd0);
    check("done_single_cycle", 32'(bus.odone), 32'd0);
    check("peak_held", bus.opeak_value, v.peak);
    check("reads_left", 32'(addr_q.size()), 32'd0);
    check("samples_left", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic pulse_foreign_start(input int at_idx);
    int n = 0;
    while (!(bus.osample_valid && bus.osample_index == idx_t'(at_idx)) && n < 2000) begin
      @(negedge crx_clk);
      n++;
    end
    if (n >= 2000) fail("inject_timeout", "index not reached", "index reached");
    bus.istart        = 1'b1;
    bus.iunit_sel     = 2'd3;
    bus.ibuff_flag    = 1'b1;
    bus.istart_offset = 7'd77;
    @(posedge crx_clk);
    #1;
    bus.istart = 1'b0;
    check("busy_kept", 32'(bus.obusy), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(bus.osample_valid), 32'd0);
    check({tag, "_sample"}, bus.osample, 32'd0);
    check({tag, "_index"}, 32'(bus.osample_index), 32'd0);
    check({tag, "_last"}, 32'(bus.olast), 32'd0);
    check({tag, "_busy"}, 32'(bus.obusy), 32'd0);
    check({tag, "_done"}, 32'(bus.odone), 32'd0);
    check({tag, "_ram_en"}, 32'(bus.oram_r_enable), 32'd0);
    check({tag, "_ram_addr"}, 32'(bus.oram_r_address), 32'd0);
    check({tag, "_peak"}, bus.opeak_value, 32'd0);
    check({tag, "_peak_idx"}, 32'(bus.opeak_index), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    vec_t v5, v6;
    int d0, n;

    vecs[0] = '{unit: 2'd0, flag: 1'b1, offset: 7'd0,   pattern: 0, rdy_mode: 0,
                peak: 32'sd127, peak_idx: 7'd127};
    vecs[1] = '{unit: 2'd2, flag: 1'b0, offset: 7'd100, pattern: 0, rdy_mode: 0,
                peak: 32'sd767, peak_idx: 7'd27};
    vecs[2] = '{unit: 2'd1, flag: 1'b1, offset: 7'd37,  pattern: 0, rdy_mode: 1,
                peak: 32'sd383, peak_idx: 7'd90};
    vecs[3] = '{unit: 2'd3, flag: 1'b0, offset: 7'd5,   pattern: 1, rdy_mode: 0,
                peak: -32'sd1,  peak_idx: 7'd40};
    v5      = '{unit: 2'd1, flag: 1'b0, offset: 7'd3,   pattern: 0, rdy_mode: 0,
                peak: 32'sd511, peak_idx: 7'd124};
    v6      = '{unit: 2'd3, flag: 1'b1, offset: 7'd50,  pattern: 0, rdy_mode: 2,
                peak: 32'sd0,   peak_idx: 7'd0};

    bus.istart = 1'b0;
    bus.iunit_sel = '0;
    bus.ibuff_flag = 1'b0;
    bus.istart_offset = '0;

    @(posedge crx_clk);
    #1;
    check_all_zero("reset");
    @(negedge crx_clk);
    rrx_rst = 1'b1;
    repeat (2) @(posedge crx_clk);
    #1;
    check_all_zero("idle");

    for (int k = 0; k < 4; k++) run_window(vecs[k]);

    // Foreign istart pulses while busy must be ignored.
    d0 = done_cnt;
    fork
      run_window(v5);
      begin
        pulse_foreign_start(10);
        pulse_foreign_start(60);
      end
    join
    repeat (5) @(posedge crx_clk);
    #1;
    check("ignored_start_done_total", 32'(done_cnt - d0), 32'd1);
    check("ignored_start_idle", 32'(bus.obusy), 32'd0);

    // Asynchronous reset in the middle of a stalled read.
    arm(v6);
    d0 = done_cnt;
    start(v6);
    n = 0;
    while (!(bus.osample_valid && bus.osample_index == idx_t'(64)) && n < 2000) begin
      @(negedge crx_clk);
      n++;
    end
    if (n >= 2000) fail("reset_point_timeout", "index 64 not reached", "index 64");
    #2;
    rrx_rst = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    addr_q.delete();
    rdy_mode = 0;
    repeat (2) @(posedge crx_clk);
    @(negedge crx_clk);
    rrx_rst = 1'b1;
    repeat (3) @(posedge crx_clk);
    #1;
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    check("midreset_busy", 32'(bus.obusy), 32'd0);
    run_window(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
